// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 digest streaming blocks.
//   DIGEST_W   : width of a SHA-256 digest (H0..H7, 8 x 32 bits)
//   tx_state_e : transmitter FSM state (IDLE, SEND)
package sha256_pkg;

    localparam int unsigned DIGEST_W = 256;

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_e;

endpackage

// File: rtl/sha256_digest_tx.sv
// Streams a 256-bit SHA-256 digest out as a frame of BEAT_W-bit beats, MSB
// (H0, big-endian) first, over a valid/ready handshake.
//
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   digest_in    : digest from the hash core (H0 in [255:224])
//   digest_valid : single-cycle strobe, digest_in valid this cycle
//   tx_data      : current beat
//   tx_valid     : tx_data holds a valid beat
//   tx_ready     : downstream accepts the beat when tx_valid && tx_ready
//   tx_last      : final beat of the frame
//   busy         : a frame is captured and not fully sent
//   overrun      : sticky, a digest strobe arrived while busy and was dropped
//   clr_overrun  : synchronous clear of overrun (a same-cycle set wins)
//
// BEAT_W must be 8, 16, 32 or 64.
module sha256_digest_tx
    import sha256_pkg::*;
#(
    parameter int unsigned BEAT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DIGEST_W-1:0] digest_in,
    input  logic                digest_valid,
    output logic [BEAT_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                tx_last,
    output logic                busy,
    output logic                overrun,
    input  logic                clr_overrun
);

    localparam int unsigned BEATS = DIGEST_W / BEAT_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
    // Beat index whose handshake makes the next beat the last one.
    localparam logic [CNT_W-1:0] PEN_CNT  = CNT_W'(BEATS - 2);

    tx_state_e           state_q;
    logic [DIGEST_W-1:0] shreg_q;
    logic [CNT_W-1:0]    cnt_q;

    logic hs;
    logic last_hs;
    logic accept;
    logic load;

    // tx_data is taken straight from flop bits, so it stays a registered output.
    assign tx_data = shreg_q[DIGEST_W-1 -: BEAT_W];

    always_comb begin
        hs      = tx_valid && tx_ready;
        last_hs = hs && (cnt_q == LAST_CNT);
        // A new digest fits only when idle or when the last beat leaves this cycle.
        accept  = (state_q == IDLE) || last_hs;
        load    = digest_valid && accept;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (digest_valid && !accept) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            if (load) begin
                state_q  <= SEND;
                shreg_q  <= digest_in;
                cnt_q    <= '0;
                tx_valid <= 1'b1;
                busy     <= 1'b1;
                tx_last  <= 1'b0;
            end else if (hs) begin
                shreg_q <= shreg_q << BEAT_W;
                if (last_hs) begin
                    state_q  <= IDLE;
                    cnt_q    <= '0;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    tx_last  <= 1'b0;
                end else begin
                    cnt_q   <= cnt_q + 1'b1;
                    tx_last <= (cnt_q == PEN_CNT);
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_digest_tx.sv
// Self-checking bench for sha256_digest_tx: directed frame table, hand-written
// corner sequences, and a randomized run against a beat-queue reference model.
module tb_sha256_digest_tx;

    localparam logic [255:0] ABC_D =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_D =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [255:0] digest_in = '0;
    logic         digest_valid = 1'b0;
    logic         tx_ready = 1'b0;
    logic         clr_overrun = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_valid, tx_last, busy, overrun;

    logic         dv32 = 1'b0;
    logic         rdy32 = 1'b0;
    logic         clr32 = 1'b0;
    logic [31:0]  tx_data32;
    logic         tx_valid32, tx_last32, busy32, ovr32;

    sha256_digest_tx #(.BEAT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .digest_in    (digest_in),
        .digest_valid (digest_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_last      (tx_last),
        .busy         (busy),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun)
    );

    sha256_digest_tx #(.BEAT_W(32)) dut32 (
        .clk          (clk),
        .reset        (reset),
        .digest_in    (digest_in),
        .digest_valid (dv32),
        .tx_data      (tx_data32),
        .tx_valid     (tx_valid32),
        .tx_ready     (rdy32),
        .tx_last      (tx_last32),
        .busy         (busy32),
        .overrun      (ovr32),
        .clr_overrun  (clr32)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bytes still to be sent in the current frame, plus the sticky flag.
    logic [7:0] m_q[$];
    bit         m_ovr = 1'b0;

    typedef struct {
        logic [255:0] digest;
        bit           toggle;
        logic [7:0]   first_b;
        logic [7:0]   second_b;
        logic [7:0]   last_b;
        int           span;
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_load(input logic [255:0] d);
        m_q.delete();
        for (int i = 0; i < 32; i++) m_q.push_back(d[255 - 8 * i -: 8]);
    endfunction

    // Advance the model by one rising edge using the inputs presented to it.
    function automatic void m_tick();
        bit sending, done, drop;
        if (!reset) begin
            m_q.delete();
            m_ovr = 1'b0;
            return;
        end
        sending = (m_q.size() > 0);
        done    = 1'b0;
        drop    = 1'b0;
        if (sending && tx_ready) begin
            m_q.delete(0);
            done = (m_q.size() == 0);
        end
        if (digest_valid) begin
            if (!sending || done) m_load(digest_in);
            else drop = 1'b1;
        end
        m_ovr = drop || (m_ovr && !clr_overrun);
    endfunction

    task automatic check_all();
        chk("tx_valid", 64'(tx_valid), 64'(m_q.size() > 0));
        chk("busy", 64'(busy), 64'(m_q.size() > 0));
        chk("tx_last", 64'(tx_last), 64'(m_q.size() == 1));
        chk("overrun", 64'(overrun), 64'(m_ovr));
        if (m_q.size() > 0) chk("tx_data", 64'(tx_data), 64'(m_q[0]));
    endtask

    task automatic step();
        @(posedge clk);
        m_tick();
        #1;
        check_all();
    endtask

    task automatic drain();
        int guard = 0;
        tx_ready = 1'b1;
        while (tx_valid && guard < 100) begin
            step();
            guard++;
        end
        chk("drain_done", 64'(tx_valid), 64'd0);
    endtask

    task automatic run_frame(input vec_t v);
        logic [7:0] got[$];
        int span = 0;
        int last_idx = -1;
        digest_in    = v.digest;
        digest_valid = 1'b1;
        tx_ready     = 1'b1;
        step();
        digest_valid = 1'b0;
        while (tx_valid && span < 200) begin
            tx_ready = v.toggle ? (span % 2 == 0) : 1'b1;
            if (tx_ready) begin
                got.push_back(tx_data);
                if (tx_last) last_idx = got.size() - 1;
            end
            span++;
            step();
        end
        chk("frame_span", 64'(span), 64'(v.span));
        chk("beat_count", 64'(got.size()), 64'd32);
        chk("last_index", 64'(last_idx), 64'd31);
        if (got.size() >= 32) begin
            chk("first_beat", 64'(got[0]), 64'(v.first_b));
            chk("second_beat", 64'(got[1]), 64'(v.second_b));
            chk("last_beat", 64'(got[31]), 64'(v.last_b));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checked", n_vec);
        $fatal(1);
    end

    initial begin
        logic [31:0] got32[$];
        int          last32;
        int          guard;

        vecs[0] = '{ABC_D,   1'b0, 8'hba, 8'h78, 8'had, 32};
        vecs[1] = '{ABC_D,   1'b1, 8'hba, 8'h78, 8'had, 63};
        vecs[2] = '{EMPTY_D, 1'b0, 8'he3, 8'hb0, 8'h55, 32};

        // Reset state.
        #2 reset = 1'b0;
        step();
        step();
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        reset = 1'b1;

        // First frame strobes in the very first cycle after release.
        foreach (vecs[i]) run_frame(vecs[i]);

        // Back-to-back: new strobe coincident with last-beat handshake.
        digest_in = ABC_D;
        digest_valid = 1'b1;
        tx_ready = 1'b1;
        step();
        digest_valid = 1'b0;
        guard = 0;
        while (!tx_last && guard < 100) begin
            step();
            guard++;
        end
        chk("b2b_reach_last", 64'(tx_last), 64'd1);
        digest_in = EMPTY_D;
        digest_valid = 1'b1;
        step();
        digest_valid = 1'b0;
        chk("b2b_valid", 64'(tx_valid), 64'd1);
        chk("b2b_first", 64'(tx_data), 64'he3);
        chk("b2b_overrun", 64'(overrun), 64'd0);
        drain();

        // Dropped strobe at beat 5.
        digest_in = ABC_D;
        digest_valid = 1'b1;
        step();
        digest_valid = 1'b0;
        repeat (5) step();
        digest_in = EMPTY_D;
        digest_valid = 1'b1;
        step();
        digest_valid = 1'b0;
        chk("ovr_set", 64'(overrun), 64'd1);
        chk("ovr_frame_continues", 64'(tx_data), 64'(ABC_D[255 - 8 * 6 -: 8]));
        drain();
        repeat (3) step();
        chk("ovr_sticky", 64'(overrun), 64'd1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        chk("ovr_cleared", 64'(overrun), 64'd0);
        digest_in = ABC_D;
        digest_valid = 1'b1;
        step();
        digest_valid = 1'b0;
        step();
        digest_valid = 1'b1;
        clr_overrun = 1'b1;
        step();
        digest_valid = 1'b0;
        clr_overrun = 1'b0;
        chk("ovr_set_wins", 64'(overrun), 64'd1);
        drain();
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;

        // Reset mid-frame at beat 10, with overrun also set.
        digest_in = ABC_D;
        digest_valid = 1'b1;
        step();
        digest_valid = 1'b0;
        repeat (3) step();
        digest_valid = 1'b1;
        step();
        digest_valid = 1'b0;
        repeat (6) step();
        reset = 1'b0;
        #1;
        chk("amid_tx_valid", 64'(tx_valid), 64'd0);
        chk("amid_busy", 64'(busy), 64'd0);
        chk("amid_tx_last", 64'(tx_last), 64'd0);
        chk("amid_tx_data", 64'(tx_data), 64'd0);
        chk("amid_overrun", 64'(overrun), 64'd0);
        m_q.delete();
        m_ovr = 1'b0;
        step();
        reset = 1'b1;
        repeat (5) begin
            step();
            chk("post_rst_idle", 64'(tx_valid), 64'd0);
        end

        // 32-bit build.
        digest_in = ABC_D;
        dv32 = 1'b1;
        rdy32 = 1'b1;
        step();
        dv32 = 1'b0;
        last32 = -1;
        guard = 0;
        while (tx_valid32 && guard < 20) begin
            got32.push_back(tx_data32);
            if (tx_last32) last32 = got32.size() - 1;
            step();
            guard++;
        end
        chk("w32_count", 64'(got32.size()), 64'd8);
        chk("w32_last_idx", 64'(last32), 64'd7);
        if (got32.size() >= 8) begin
            chk("w32_first", 64'(got32[0]), 64'hba7816bf);
            chk("w32_last", 64'(got32[7]), 64'hf20015ad);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            digest_valid = ($urandom_range(0, 29) == 0);
            if (digest_valid) begin
                for (int k = 0; k < 8; k++) digest_in[32 * k +: 32] = $urandom();
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            clr_overrun = ($urandom_range(0, 49) == 0);
            step();
        end
        digest_valid = 1'b0;
        clr_overrun = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
